// File: rtl/dff_set_pipe.sv
// Collapsing valid/ready pipeline of DEPTH stages with synchronous set (all stages SET_VAL, valid) and flush.
// A word needs DEPTH cycles to reach the output; bubbles fill under stall, so in_ready drops only when every stage is full.
module dff_set_pipe #(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       set,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic                 hold;
  logic [DEPTH-1:0]     move;
  logic                 slot0_free;
  logic                 in_fire;
  logic                 out_fire;
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [WIDTH-1:0]     dat_q [DEPTH];
  logic [WIDTH-1:0]     dat_d [DEPTH];
  logic [OCC_W-1:0]     occ_q, occ_d;

  assign hold = set | flush;

  // Walk from the output back: a stage may advance when the slot ahead is empty or is itself draining.
  always_comb begin : move_chain
    logic go;
    go   = out_ready & ~hold;
    move = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      move[i] = vld_q[i] & go;
      go      = ~vld_q[i] | move[i];
    end
    slot0_free = go;
  end

  assign in_ready  = rst & ~hold & slot0_free;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = move[DEPTH-1];
  assign out_valid = vld_q[DEPTH-1] & ~hold;
  assign out_data  = dat_q[DEPTH-1];
  assign occupancy = occ_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    occ_d = occ_q;
    if (set) begin
      vld_d = '1;
      for (int i = 0; i < DEPTH; i++) dat_d[i] = SET_VAL;
      occ_d = OCC_W'(DEPTH);
    end else if (flush) begin
      vld_d = '0;
      occ_d = '0;
    end else begin
      for (int i = DEPTH-1; i >= 1; i--) begin
        if (move[i-1]) begin
          vld_d[i] = 1'b1;
          dat_d[i] = dat_q[i-1];
        end else if (move[i]) begin
          vld_d[i] = 1'b0;
        end
      end
      if (in_fire) begin
        vld_d[0] = 1'b1;
        dat_d[0] = in_data;
      end else if (move[0]) begin
        vld_d[0] = 1'b0;
      end
      if (in_fire & ~out_fire)
        occ_d = occ_q + OCC_W'(1);
      else if (out_fire & ~in_fire)
        occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= RST_VAL;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      occ_q <= occ_d;
    end
  end

endmodule
